// File: rtl/multi_op_seq.sv
// multi_op_seq: handshaked signed add/sub/mul/mac with an iterative one-bit-per-cycle multiplier.
// Define MULTI_OP_ACC_EN to give mac a running internal accumulator in place of the C addend.
`timescale 1ns/1ps
module multi_op_seq #(
  parameter int N = 64,
  parameter int M = 64
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic signed [N-1:0]   A,
  input  logic signed [M-1:0]   B,
  input  logic signed [N+M+1:0] C,
  input  logic                  S0,
  input  logic                  S1,
  input  logic                  ACC_CLR,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic signed [N+M+1:0] Y,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);
  localparam int W  = N + M + 2;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]       cnt;
  logic                fin;
  logic                is_mul;
  logic                is_neg;
  logic                accept;
  logic                last;
  logic signed [W-1:0] a_sh;
  logic signed [W-1:0] b_sh;
  logic signed [W-1:0] partial;
  logic signed [W-1:0] y_r;
  logic signed [W-1:0] preload;

  // The top bit of B carries negative weight, so its partial product is subtracted.
  function automatic logic signed [W-1:0] mul_step(input logic signed [W-1:0] sum,
                                                   input logic signed [W-1:0] a_in,
                                                   input logic            bit_in,
                                                   input logic            neg);
    logic signed [W-1:0] addend;
    addend = bit_in ? a_in : '0;
    return neg ? sum - addend : sum + addend;
  endfunction

  assign accept = (state == IDLE) && IN_VALID;
  assign last   = (cnt == CW'(M - 1));

`ifdef MULTI_OP_ACC_EN
  logic signed [W-1:0] acc;
  logic                unused_c;
  assign unused_c = ^C;
  assign preload  = (S1 && S0 && !ACC_CLR) ? acc : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      acc <= '0;
    else if (state == DONE && OUT_READY && is_mul && is_neg)
      acc <= y_r;
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = ACC_CLR;
  assign preload        = (S1 && S0) ? C : '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID)  state_nxt = CALC;
      CALC:    if (fin)       state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: state, iteration count, mode and the registered result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      fin    <= 1'b0;
      is_mul <= 1'b0;
      is_neg <= 1'b0;
      y_r    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= '0;
        fin    <= 1'b0;
        is_mul <= S1;
        is_neg <= S0;
      end else if (state == CALC) begin
        if (fin)
          y_r <= partial;
        else if (!is_mul || last)
          fin <= 1'b1;
        else
          cnt <= cnt + 1'b1;
      end
    end
  end

  // Datapath: operands shift one bit per multiply iteration.
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_sh    <= {{(M+2){A[N-1]}}, A};
      b_sh    <= {{(N+2){B[M-1]}}, B};
      partial <= preload;
    end else if (state == CALC && !fin) begin
      if (!is_mul) begin
        partial <= is_neg ? a_sh - b_sh : a_sh + b_sh;
      end else begin
        partial <= mul_step(partial, a_sh, b_sh[0], last);
        a_sh    <= a_sh <<< 1;
        b_sh    <= b_sh >>> 1;
      end
    end
  end

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign Y         = y_r;

endmodule

// File: tb/tb_multi_op_seq.sv
// Testbench for multi_op_seq (N=M=8): directed table, backpressure, async reset and random ops.
`timescale 1ns/1ps
module tb_multi_op_seq;
  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [7:0]   a;
  logic signed [7:0]   b;
  logic signed [17:0]  c;
  logic                s0, s1, acc_clr, in_valid, out_ready;
  logic                in_ready, out_valid;
  logic signed [17:0]  y;

  int     checks = 0;
  int     errors = 0;
  longint acc_m  = 0;

  multi_op_seq #(.N(8), .M(8)) dut (
    .CLK(clk), .RST_N(rst_n), .A(a), .B(b), .C(c), .S0(s0), .S1(s1),
    .ACC_CLR(acc_clr), .IN_VALID(in_valid), .IN_READY(in_ready),
    .Y(y), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0]  a;
    logic signed [7:0]  b;
    logic signed [17:0] c;
    logic               s0;
    logic               s1;
    logic               clr;
    longint             y;
  } vec_t;

  function automatic vec_t mk(int va, int vb, int vc, bit v0, bit v1, bit vclr, longint vy);
    vec_t v;
    v.a = 8'(va); v.b = 8'(vb); v.c = 18'(vc);
    v.s0 = v0; v.s1 = v1; v.clr = vclr; v.y = vy;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint wrap18(input longint v);
    logic [17:0] t;
    t = v[17:0];
    return longint'($signed(t));
  endfunction

  // Reference: plain signed arithmetic on the operands, wrapped to the 18-bit result.
  function automatic longint model(input longint va, input longint vb, input longint vc,
                                   input bit v0, input bit v1, input bit vclr);
    longint r;
    case ({v0, v1})
      2'b00:   r = va + vb;
      2'b10:   r = va - vb;
      2'b01:   r = va * vb;
`ifdef MULTI_OP_ACC_EN
      default: r = va * vb + (vclr ? 0 : acc_m);
`else
      default: r = va * vb + vc;
`endif
    endcase
    return wrap18(r);
  endfunction

  task automatic do_op(input logic signed [7:0] va, input logic signed [7:0] vb,
                       input logic signed [17:0] vc, input bit v0, input bit v1,
                       input bit vclr, input int stall,
                       output longint got, output longint exp, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin step(); guard++; end
    chk("ready_before_accept", in_ready, 1);
    exp = model(va, vb, vc, v0, v1, vclr);
    a = va; b = vb; c = vc; s0 = v0; s1 = v1; acc_clr = vclr;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    lat = 0;
    while (!out_valid && lat < 100) begin
      a = 8'($urandom); b = 8'($urandom); c = 18'($urandom);
      acc_clr = 1'($urandom); in_valid = 1'($urandom);
      step();
      lat++;
    end
    chk("done_reached", out_valid, 1);
    got = y;
    for (int i = 0; i < stall; i++) begin
      a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom);
      step();
      chk("hold_y", y, got);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
    out_ready = 1'b0;
`ifdef MULTI_OP_ACC_EN
    if (v0 && v1) acc_m = exp;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[$];
    longint got, exp;
    int     lat;

    a = '0; b = '0; c = '0; s0 = 0; s1 = 0; acc_clr = 0;
    in_valid = 0; out_ready = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y", y, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_out_valid", out_valid, 0);

    tbl.push_back(mk(-128, -128, 0, 0, 0, 0, -256));
    tbl.push_back(mk(127, -128, 0, 1, 0, 0, 255));
    tbl.push_back(mk(-128, -128, 0, 0, 1, 0, 16384));
    tbl.push_back(mk(-1, 1, 0, 0, 1, 0, -1));
    tbl.push_back(mk(127, 127, 0, 0, 1, 0, 16129));
    tbl.push_back(mk(-128, 127, 0, 1, 0, 0, -255));
`ifdef MULTI_OP_ACC_EN
    tbl.push_back(mk(3, 4, 999, 1, 1, 1, 12));
    tbl.push_back(mk(2, 5, 999, 1, 1, 0, 22));
    tbl.push_back(mk(10, 20, 0, 0, 0, 0, 30));
    tbl.push_back(mk(1, 1, -500, 1, 1, 0, 23));
`else
    tbl.push_back(mk(-3, 5, 100, 1, 1, 1, 85));
    tbl.push_back(mk(127, -128, -131072, 1, 1, 0, 114816));
`endif
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s0, tbl[i].s1, tbl[i].clr, 0, got, exp, lat);
      chk($sformatf("table%0d_y", i), got, tbl[i].y);
      chk($sformatf("table%0d_lat", i), lat, tbl[i].s1 ? 9 : 2);
    end

    do_op(11, -13, 0, 0, 1, 0, 10, got, exp, lat);
    chk("backpressure_y", got, -143);
    chk("backpressure_lat", lat, 9);

    a = 5; b = 7; s0 = 0; s1 = 1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_out_valid", out_valid, 0);
    chk("midop_reset_y", y, 0);
    chk("midop_reset_in_ready", in_ready, 1);
    acc_m = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("after_release_in_ready", in_ready, 1);
    do_op(-7, 9, 0, 0, 1, 0, 0, got, exp, lat);
    chk("after_reset_mul_y", got, -63);
    chk("after_reset_mul_lat", lat, 9);

    for (int n = 0; n < 2000; n++) begin
      logic signed [7:0]  ra, rb;
      logic signed [17:0] rc;
      bit                 r0, r1, rclr;
      ra = 8'($urandom); rb = 8'($urandom); rc = 18'($urandom);
      r0 = 1'($urandom); r1 = 1'($urandom);
      rclr = ($urandom_range(0, 3) == 0);
      do_op(ra, rb, rc, r0, r1, rclr, $urandom_range(0, 3), got, exp, lat);
      chk("rand_y", got, exp);
      chk("rand_lat", lat, r1 ? 9 : 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
